mult_ctrl: RTL and testbench
============================

# mult_ctrl

Sequencing controller for the shift-add multiplier datapath. It latches a multiplicand/multiplier pair on a start handshake and (re)initialises the 2W+1-bit accumulate/shift register. It then drives the one-hot ADD/SHIFT strobes for W bit-iterations, steering each iteration from the register LSB. When the iterations finish it captures the 2W-bit product and holds it behind a valid/ready output handshake. It sits directly upstream of the accumulate/shift register stage and the W-bit adder.

## Interface
Parameters:
- WIDTH, 4, operand width W; accumulate register is 2W+1 bits, product is 2W bits.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; sampled on rising clk.
- start  in  1  request; accepted only in IDLE.
- a  in  W  multiplicand, sampled on accept.
- b  in  W  multiplier, sampled on accept.
- busy  out  1  high in every state except IDLE.
- mcand  out  W  latched multiplicand, feeds adder.
- mplier  out  W  latched multiplier, feeds register load value.
- load_n  out  1  active-low (re)initialise strobe to the accumulate register.
- ADD  out  1  accumulate strobe: register[2W:W] <= {carry,sum}.
- SHIFT  out  1  shift strobe: register <= {0, register[2W:1]}.
- reg_lsb  in  1  register[0] from the datapath.
- reg_prod  in  2W  register[2W-1:0] from the datapath.
- product  out  2W  captured result.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.

## Operation
- States: IDLE, LOAD, BIT, SHIFT, DONE. Enum encoding; outputs are decoded from registered state only.
- IDLE: busy=0. On start=1, latch a→mcand and b→mplier, clear iteration counter, then go to LOAD.
- LOAD: load_n=0 for exactly one cycle, so the register takes {0,mplier}. Then go to BIT.
- BIT: ADD=reg_lsb, SHIFT=0. Then go to SHIFT.
- SHIFT: SHIFT=1, ADD=0. Counter increments. If counter==W-1 before the increment, capture reg_prod as it will be after this shift and go to DONE. Otherwise go to BIT.
- Capture rule: product <= {0,reg_prod[2W-1:1]} combined with the register MSB. Equivalently, and preferred, capture reg_prod in the first DONE cycle. The chosen implementation registers product on DONE entry +1 edge; out_valid rises with it.
- DONE: out_valid=1. product and out_valid are held stable until out_ready=1. On out_valid&out_ready, go to IDLE with out_valid=0.
- ADD and SHIFT are never high together. load_n is never low while ADD or SHIFT is high.
- Counter width is clog2(W). There is no wrap inside an operation; the counter clears on accept.

## Timing
- Reset values: state IDLE, busy 0, ADD 0, SHIFT 0, load_n 1, out_valid 0, product 0, mcand 0, mplier 0, counter 0.
- Cycle-by-cycle, with accept at edge 0:
  - LOAD in cycle 1.
  - BIT/SHIFT pairs in cycles 2..2W+1.
  - DONE entered in cycle 2W+2; product registered at the end of that cycle.
  - out_valid=1 from cycle 2W+3 (cycle 11 for W=4).
- Fixed latency regardless of operand values; no early exit for zero bits.
- start while busy=1: ignored, no latch.
- start and out_ready both high in DONE: the handshake completes, start is ignored, and the next accept happens in IDLE at the earliest.
- a/b changes after accept: no effect.
- reset asserted in any state: all outputs return to reset values at the next edge. An in-flight product is discarded, and no ADD/SHIFT pulse is issued in the cycle after the reset edge.

## Structure
- Shared package mult_pkg: WIDTH default constant, state_t enum (IDLE, LOAD, BIT, SHIFT, DONE), and a CNT_W = $clog2(WIDTH) localparam.
- Single module, no sub-module. The iteration counter is inline.

## Test plan
Bench pairs mult_ctrl with the accumulate register and a W-bit adder model; W=4.
- a=13, b=11, start pulse → ADD high in iterations 0, 1 and 3. out_valid at cycle 11 with product=143 (0x8F).
- a=15, b=0 → ADD never high, 4 SHIFT pulses, product=0.
- a=15, b=15 → 4 ADD pulses with carry set; product=225 (0xE1).
- a=9, b=7 → product=63. Hold out_ready=0 for 5 cycles: product and out_valid stay constant and busy=1. Then out_ready=1 → IDLE next cycle.
- start=1 held through an entire operation with new a/b → no re-accept until IDLE; the second result is computed from the operands sampled at the second accept.
- Assert reset during the third BIT cycle → next cycle in IDLE, all outputs at reset values. A following a=6, b=5 returns product=30.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-add multiplier sequencing controller.
package mult_pkg;

    localparam int MULT_WIDTH = 4;

    // Iteration counter width; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_W = cnt_width(MULT_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_BIT,
        S_SHIFT,
        S_DONE
    } state_t;

endpackage

// File: rtl/mult_ctrl.sv
// Sequencer for the shift-add multiplier: latches operands, strobes LOAD/ADD/SHIFT
// for WIDTH iterations, then holds the product behind a valid/ready handshake.
//
// Output handshake: a product transfers on any rising edge where out_valid and
// out_ready are both high; out_valid and product stay stable until that edge.
module mult_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic [WIDTH-1:0]     mcand,
    output logic [WIDTH-1:0]     mplier,
    output logic                 load_n,
    output logic                 ADD,
    output logic                 SHIFT,
    input  logic                 reg_lsb,
    input  logic [2*WIDTH-1:0]   reg_prod,
    output logic [2*WIDTH-1:0]   product,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 valid_q, valid_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            product_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            product_q <= product_d;
            valid_q   <= valid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        product_d = product_q;
        valid_d   = valid_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d  = a;
                    mplier_d = b;
                    cnt_d    = '0;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD:  state_d = S_BIT;
            S_BIT:   state_d = S_SHIFT;
            S_SHIFT: begin
                // The counter stops at the last iteration instead of wrapping.
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = S_BIT;
                end
            end
            S_DONE: begin
                // First DONE cycle: the final shift has landed, so reg_prod is the result.
                if (!valid_q) begin
                    product_d = reg_prod;
                    valid_d   = 1'b1;
                end else if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign load_n    = (state_q != S_LOAD);
    assign ADD       = (state_q == S_BIT) && reg_lsb;
    assign SHIFT     = (state_q == S_SHIFT);
    assign mcand     = mcand_q;
    assign mplier    = mplier_q;
    assign product   = product_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_mult_ctrl.sv
// Bench for mult_ctrl: pairs the controller with an accumulate/shift register and
// adder, and checks it against a timing/arithmetic model every cycle.
`timescale 1ns/1ps
module tb_mult_ctrl;

    localparam int W = 4;
    localparam int P = 2 * W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset, start, out_ready;
    logic [W-1:0]   a, b, mcand, mplier;
    logic           busy, load_n, add_strobe, shift_strobe, out_valid;
    logic           reg_lsb;
    logic [P-1:0]   reg_prod, product;
    logic [P:0]     acc;
    bit             cmp_en = 1'b0;

    mult_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .busy(busy), .mcand(mcand), .mplier(mplier), .load_n(load_n),
        .ADD(add_strobe), .SHIFT(shift_strobe), .reg_lsb(reg_lsb),
        .reg_prod(reg_prod), .product(product), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    // Accumulate/shift register and W-bit adder downstream of the controller.
    always @(posedge clk) begin
        if (reset)
            acc <= '0;
        else if (!load_n)
            acc <= {1'b0, {W{1'b0}}, mplier};
        else if (add_strobe)
            acc[P:W] <= {1'b0, acc[P-1:W]} + {1'b0, mcand};
        else if (shift_strobe)
            acc <= {1'b0, acc[P:1]};
    end
    assign reg_lsb  = acc[0];
    assign reg_prod = acc[P-1:0];

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [P-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: m_t counts cycles since accept (1 = load cycle); result is plain a*b.
    bit           m_active;
    int           m_t;
    logic [W-1:0] m_a, m_b;
    logic [P-1:0] m_prod;

    always @(posedge clk) begin
        if (reset) begin
            m_active = 1'b0;
            m_t      = 0;
            m_a      = '0;
            m_b      = '0;
            m_prod   = '0;
            exp_q.delete();
        end else if (!m_active) begin
            if (start) begin
                m_active = 1'b1;
                m_t      = 1;
                m_a      = a;
                m_b      = b;
                exp_q.push_back({{W{1'b0}}, a} * {{W{1'b0}}, b});
            end
        end else if (m_t >= 2 * W + 3 && out_ready) begin
            m_active = 1'b0;
            m_t      = 0;
        end else begin
            m_t++;
            if (m_t == 2 * W + 3)
                m_prod = {{W{1'b0}}, m_a} * {{W{1'b0}}, m_b};
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic in_iter, e_add, e_shift;
            in_iter = m_active && m_t >= 2 && m_t <= 2 * W + 1;
            e_add   = in_iter && (m_t % 2 == 0) && m_b[(m_t - 2) / 2];
            e_shift = in_iter && (m_t % 2 == 1);
            chk("busy",      32'(busy),         32'(m_active));
            chk("load_n",    32'(load_n),       32'(!(m_active && m_t == 1)));
            chk("add",       32'(add_strobe),   32'(e_add));
            chk("shift",     32'(shift_strobe), 32'(e_shift));
            chk("out_valid", 32'(out_valid),    32'(m_active && m_t >= 2 * W + 3));
            chk("mcand",     32'(mcand),        32'(m_a));
            chk("mplier",    32'(mplier),       32'(m_b));
            chk("product",   32'(product),      32'(m_prod));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0)
                    chk("sb_nonempty", 32'(exp_q.size()), 32'd1);
                else
                    chk("sb_product", 32'(product), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        chk("idle_wait", 32'(busy), 32'd0);
    endtask

    task automatic do_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input int hold,
                         input logic [P-1:0] want, input logic [W-1:0] want_mask,
                         input bit want_carry);
        int k, vc, nshift;
        logic [W-1:0] mask;
        bit carry_seen;
        wait_idle();
        start = 1'b1;
        a = ai;
        b = bi;
        tick();
        start = 1'b0;
        a = W'($urandom_range(0, 15));
        b = W'($urandom_range(0, 15));
        chk("load_c1",   32'(load_n), 32'd0);
        chk("mcand_lat", 32'(mcand),  32'(ai));
        chk("mplier_lat", 32'(mplier), 32'(bi));
        k = 1; vc = 0; nshift = 0; mask = '0; carry_seen = 1'b0;
        while (vc == 0 && k <= 40) begin
            if (add_strobe && k >= 2 && (k - 2) / 2 < W) mask[(k - 2) / 2] = 1'b1;
            if (shift_strobe) nshift++;
            if (acc[P]) carry_seen = 1'b1;
            if (out_valid) vc = k;
            else begin
                tick();
                k++;
            end
        end
        chk("valid_cycle", 32'(vc),         32'(2 * W + 3));
        chk("add_mask",    32'(mask),       32'(want_mask));
        chk("shift_count", 32'(nshift),     32'(W));
        chk("carry",       32'(carry_seen), 32'(want_carry));
        chk("result",      32'(product),    32'(want));
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("hold_valid",   32'(out_valid), 32'd1);
            chk("hold_product", 32'(product),   32'(want));
            chk("hold_busy",    32'(busy),      32'd1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("post_busy",  32'(busy),      32'd0);
        chk("post_valid", 32'(out_valid), 32'd0);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        chk(name, 32'(out_valid), 32'd1);
    endtask

    task automatic chk_reset_values();
        chk("rst_busy",    32'(busy),         32'd0);
        chk("rst_add",     32'(add_strobe),   32'd0);
        chk("rst_shift",   32'(shift_strobe), 32'd0);
        chk("rst_load_n",  32'(load_n),       32'd1);
        chk("rst_valid",   32'(out_valid),    32'd0);
        chk("rst_product", 32'(product),      32'd0);
        chk("rst_mcand",   32'(mcand),        32'd0);
        chk("rst_mplier",  32'(mplier),       32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; start = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        tick();
        tick();
        cmp_en = 1'b1;
        chk_reset_values();
        reset = 1'b0;
        tick();

        do_op(4'd13, 4'd11, 0, 8'h8F, 4'b1011, 1'b1);
        do_op(4'd15, 4'd0,  0, 8'd0,  4'b0000, 1'b0);
        do_op(4'd15, 4'd15, 0, 8'hE1, 4'b1111, 1'b1);
        do_op(4'd9,  4'd7,  5, 8'd63, 4'b0111, 1'b0);

        // start held high across a whole operation with fresh operands
        wait_idle();
        start = 1'b1; a = 4'd3; b = 4'd5;
        tick();
        a = 4'd7; b = 4'd2;
        wait_valid("held_valid1");
        chk("held_prod1",  32'(product), 32'd15);
        chk("held_mcand1", 32'(mcand),   32'd3);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("held_idle", 32'(busy), 32'd0);
        tick();
        chk("held_reaccept", 32'(busy),   32'd1);
        chk("held_mcand2",   32'(mcand),  32'd7);
        chk("held_mplier2",  32'(mplier), 32'd2);
        start = 1'b0;
        wait_valid("held_valid2");
        chk("held_prod2", 32'(product), 32'd14);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // reset during the third BIT cycle (cycle 6 after accept)
        wait_idle();
        start = 1'b1; a = 4'd10; b = 4'd13;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("bit3_add",   32'(add_strobe),   32'd1);
        chk("bit3_shift", 32'(shift_strobe), 32'd0);
        reset = 1'b1;
        tick();
        chk_reset_values();
        reset = 1'b0;
        tick();
        do_op(4'd6, 4'd5, 0, 8'd30, 4'b0101, 1'b0);

        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
